keypad_entry_buffer: RTL and testbench

Consumer of the keypad scanner's key stream (digit code, key-change flag, synchronized enter). Turns held-key levels into single key events and edits an NDIG-digit BCD entry buffer (digits, backspace, clear). On enter it serially converts the buffer to binary and presents the value with a one-cycle valid strobe. Sits between the keypad scanner and the application logic (display/compare), on the same clock as the scanner.

---
 rtl/keypad_entry_buffer.sv | 157 +++++++++++++++
 tb/tb_keypad_entry_buffer.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_buffer.sv
`default_nettype none
// ============================================================================
// keypad_entry_buffer : key-event edge detect, NDIG-digit BCD entry buffer
//                       editing and serial BCD-to-binary conversion on enter
// Rev 1.0
// ============================================================================
module keypad_entry_buffer #(
  parameter int NDIG  = 4,
  parameter int VAL_W = 14
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [4:0]                 digito,
  input  logic                       cambio_digito,
  input  logic                       enter_sync,
  output logic [4*NDIG-1:0]          bcd_out,
  output logic [$clog2(NDIG+1)-1:0]  count,
  output logic [3:0]                 letra,
  output logic                       letra_valid,
  output logic                       busy,
  output logic [VAL_W-1:0]           value,
  output logic                       value_valid
);

  localparam int BCD_W = 4 * NDIG;
  localparam int CNT_W = $clog2(NDIG + 1);
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  localparam logic [CNT_W-1:0] C_NDIG     = CNT_W'(NDIG);
  localparam logic [IDX_W-1:0] C_IDX_LAST = IDX_W'(NDIG - 1);

  localparam logic [0:0] S_IDLE    = 1'b0;
  localparam logic [0:0] S_CONVERT = 1'b1;

  logic [0:0]       state_q, state_d;
  logic             cam_q, ent_q;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [3:0]       letra_q, letra_d;
  logic             letra_valid_q, letra_valid_d;
  logic [VAL_W-1:0] value_q, value_d;
  logic             value_valid_q, value_valid_d;
  logic [VAL_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             key_ev, ent_ev, start_conv, last_digit;
  logic [3:0]       cur_digit;
  logic [VAL_W-1:0] acc_next;

  assign key_ev     = cambio_digito & ~cam_q;
  assign ent_ev     = enter_sync & ~ent_q;
  assign start_conv = ent_ev && (count_q != '0);
  assign last_digit = (idx_q == '0);
  assign cur_digit  = bcd_q[{idx_q, 2'b00} +: 4];
  // acc * 10 as (acc << 3) + (acc << 1); VAL_W is sized so this never wraps
  assign acc_next   = (acc_q << 3) + (acc_q << 1) + VAL_W'(cur_digit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_conv) state_d = S_CONVERT;
      S_CONVERT: if (last_digit) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_CONVERT);
  end

  always_comb begin
    bcd_d         = bcd_q;
    count_d       = count_q;
    letra_d       = letra_q;
    letra_valid_d = 1'b0;
    value_d       = value_q;
    value_valid_d = 1'b0;
    acc_d         = acc_q;
    idx_d         = idx_q;
    if (state_q == S_IDLE) begin
      // enter wins over a simultaneous key; that key is simply dropped
      if (ent_ev) begin
        if (start_conv) begin
          acc_d = '0;
          idx_d = C_IDX_LAST;
        end
      end else if (key_ev) begin
        if (digito < 5'd10) begin
          if (count_q < C_NDIG) begin
            bcd_d   = (bcd_q << 4) | BCD_W'(digito[3:0]);
            count_d = count_q + CNT_W'(1);
          end
        end else if (digito == 5'h0E) begin
          if (count_q != '0) begin
            bcd_d   = bcd_q >> 4;
            count_d = count_q - CNT_W'(1);
          end
        end else if (digito == 5'h0F) begin
          bcd_d   = '0;
          count_d = '0;
        end else if (digito >= 5'h0A && digito <= 5'h0D) begin
          letra_d       = digito[3:0];
          letra_valid_d = 1'b1;
        end
      end
    end else begin
      acc_d = acc_next;
      idx_d = idx_q - IDX_W'(1);
      if (last_digit) begin
        value_d       = acc_next;
        value_valid_d = 1'b1;
        bcd_d         = '0;
        count_d       = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cam_q         <= 1'b0;
      ent_q         <= 1'b0;
      bcd_q         <= '0;
      count_q       <= '0;
      letra_q       <= '0;
      letra_valid_q <= 1'b0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      acc_q         <= '0;
      idx_q         <= '0;
    end else begin
      cam_q         <= cambio_digito;
      ent_q         <= enter_sync;
      bcd_q         <= bcd_d;
      count_q       <= count_d;
      letra_q       <= letra_d;
      letra_valid_q <= letra_valid_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      acc_q         <= acc_d;
      idx_q         <= idx_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign count       = count_q;
  assign letra       = letra_q;
  assign letra_valid = letra_valid_q;
  assign value       = value_q;
  assign value_valid = value_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_entry_buffer.sv
`default_nettype none
// ============================================================================
// tb_keypad_entry_buffer : directed self-checking bench for keypad_entry_buffer
// Rev 1.0
// ============================================================================
module tb_keypad_entry_buffer;

  localparam int NDIG  = 4;
  localparam int VAL_W = 14;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [4:0]                digito = 5'd16;
  logic                      cambio_digito = 1'b0;
  logic                      enter_sync = 1'b0;
  logic [4*NDIG-1:0]         bcd_out;
  logic [$clog2(NDIG+1)-1:0] count;
  logic [3:0]                letra;
  logic                      letra_valid;
  logic                      busy;
  logic [VAL_W-1:0]          value;
  logic                      value_valid;

  keypad_entry_buffer #(.NDIG(NDIG), .VAL_W(VAL_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .digito        (digito),
    .cambio_digito (cambio_digito),
    .enter_sync    (enter_sync),
    .bcd_out       (bcd_out),
    .count         (count),
    .letra         (letra),
    .letra_valid   (letra_valid),
    .busy          (busy),
    .value         (value),
    .value_valid   (value_valid)
  );

  always #5 clk = ~clk;

  int  n_chk = 0;
  int  n_fail = 0;
  int  vv_cnt = 0, lv_cnt = 0, busy_cnt = 0;
  logic prev_vv = 1'b0, prev_lv = 1'b0, dbl = 1'b0;
  time vv_t = 0, enter_t = 0;
  int  vv0, lv0, b0;

  always @(negedge clk) begin
    if (value_valid) begin
      vv_cnt <= vv_cnt + 1;
      vv_t   <= $time;
    end
    if (letra_valid) lv_cnt <= lv_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if ((value_valid && prev_vv) || (letra_valid && prev_lv)) dbl <= 1'b1;
    prev_vv <= value_valid;
    prev_lv <= letra_valid;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic [4:0] k, input int hold, input int gap);
    @(negedge clk);
    digito = k;
    cambio_digito = 1'b1;
    repeat (hold) @(negedge clk);
    cambio_digito = 1'b0;
    digito = 5'd16;
    repeat (gap) @(negedge clk);
  endtask

  task automatic snap();
    @(negedge clk);
    vv0 = vv_cnt;
    lv0 = lv_cnt;
    b0  = busy_cnt;
  endtask

  task automatic enter_and_wait();
    @(negedge clk);
    enter_sync = 1'b1;
    enter_t = $time;
    @(negedge clk);
    enter_sync = 1'b0;
    repeat (NDIG + 4) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_bcd", bcd_out, 0);
    check_eq("reset_cnt", count, 0);
    check_eq("reset_misc", {letra, letra_valid, busy, value_valid}, 0);
    check_eq("reset_value", value, 0);

    // 1: 1234 then enter
    press(5'd1, 5, 3); press(5'd2, 5, 3); press(5'd3, 5, 3); press(5'd4, 5, 3);
    check_eq("t1_bcd", bcd_out, 32'h1234);
    check_eq("t1_cnt", count, 4);
    snap();
    enter_and_wait();
    check_eq("t1_busy_cycles", busy_cnt - b0, NDIG);
    check_eq("t1_vv_pulses", vv_cnt - vv0, 1);
    check_eq("t1_value", value, 1234);
    check_eq("t1_latency", 32'((vv_t - enter_t) / 10), NDIG + 1);
    check_eq("t1_bcd_clr", bcd_out, 0);
    check_eq("t1_cnt_clr", count, 0);

    // 2: long hold gives one digit
    press(5'd5, 20, 3);
    check_eq("t2_cnt", count, 1);
    check_eq("t2_bcd", bcd_out, 32'h0005);
    press(5'h0F, 2, 2);
    check_eq("t2_clear", {count, bcd_out}, 0);

    // 3: overflow, backspace, clear, empty enter
    press(5'd9, 2, 2); press(5'd8, 2, 2); press(5'd7, 2, 2); press(5'd6, 2, 2);
    press(5'd5, 2, 2);
    check_eq("t3_full_bcd", bcd_out, 32'h9876);
    check_eq("t3_full_cnt", count, 4);
    press(5'h0E, 2, 2);
    check_eq("t3_bs_bcd", bcd_out, 32'h0987);
    check_eq("t3_bs_cnt", count, 3);
    press(5'h0F, 2, 2);
    check_eq("t3_clr", {count, bcd_out}, 0);
    press(5'h0E, 2, 2);
    check_eq("t3_bs_empty", {count, bcd_out}, 0);
    snap();
    enter_and_wait();
    check_eq("t3_empty_vv", vv_cnt - vv0, 0);
    check_eq("t3_empty_busy", busy_cnt - b0, 0);

    // 4: letter and invalid code
    snap();
    press(5'h0B, 4, 3);
    check_eq("t4_letra", letra, 4'hB);
    check_eq("t4_lv_pulses", lv_cnt - lv0, 1);
    check_eq("t4_buf", {count, bcd_out}, 0);
    press(5'd16, 3, 2);
    press(5'd17, 3, 2);
    check_eq("t4_invalid", {letra, count, bcd_out}, {4'hB, 3'd0, 16'h0});

    // 5: enter and key on same edge
    press(5'd4, 2, 2); press(5'd2, 2, 2);
    check_eq("t5_bcd", bcd_out, 32'h0042);
    snap();
    @(negedge clk);
    enter_sync = 1'b1; cambio_digito = 1'b1; digito = 5'd7;
    @(negedge clk);
    enter_sync = 1'b0;
    repeat (3) @(negedge clk);
    cambio_digito = 1'b0; digito = 5'd16;
    repeat (NDIG + 2) @(negedge clk);
    check_eq("t5_value", value, 42);
    check_eq("t5_vv_pulses", vv_cnt - vv0, 1);
    check_eq("t5_buf", {count, bcd_out}, 0);

    // 6: reset mid-conversion
    press(5'd9, 2, 2); press(5'd9, 2, 2); press(5'd9, 2, 2); press(5'd9, 2, 2);
    check_eq("t6_bcd", bcd_out, 32'h9999);
    @(negedge clk);
    enter_sync = 1'b1;
    @(negedge clk);
    enter_sync = 1'b0;
    @(negedge clk);
    check_eq("t6_busy_before", busy, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("t6_rst_bcd", {count, bcd_out}, 0);
    check_eq("t6_rst_misc", {busy, value_valid, letra, letra_valid}, 0);
    check_eq("t6_rst_value", value, 0);
    @(negedge clk);
    rst = 1'b0;
    snap();
    repeat (NDIG + 4) @(negedge clk);
    check_eq("t6_no_vv", vv_cnt - vv0, 0);
    press(5'd3, 2, 2);
    snap();
    enter_and_wait();
    check_eq("t6_value", value, 3);
    check_eq("t6_vv_pulses", vv_cnt - vv0, 1);

    check_eq("no_double_pulse", dbl, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
